// File: rtl/ksl_sched.sv
// ksl_sched: walks every operator slot once per sample tick, fetches its
// fnum/block/ksl from the register file, drives the shared KSL attenuation
// lookup and writes the result into the per-operator attenuation table.
// Each operator takes ADDR -> LOAD -> HOLD0 -> HOLD1 -> WRITE (5 cycles).
// Optional feature macro: KSL_SCHED_SKIP_EN -- operators with ksl==0 bypass
// the two lookup wait states and write 0 (3 cycles per such operator).
module ksl_sched #(
    parameter int NUM_OPS = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       clr_err,
    output logic [4:0] op_addr,
    input  logic [9:0] reg_fnum,
    input  logic [2:0] reg_block,
    input  logic [1:0] reg_ksl,
    output logic [9:0] rom_fnum,
    output logic [2:0] rom_block,
    output logic [1:0] rom_ksl,
    input  logic [7:0] rom_ksl_add,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       overrun_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LOAD  = 3'd2,
        HOLD0 = 3'd3,
        HOLD1 = 3'd4,
        WRITE = 3'd5
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_OPS - 1);

    state_t     state;
    logic [4:0] idx;

`ifdef KSL_SCHED_SKIP_EN
    logic       skip;

    // A skipped operator never waited on the lookup, so its table entry is 0.
    assign wr_data = (wr_en && !skip) ? rom_ksl_add : 8'd0;
`else
    // The lookup result is valid in WRITE because rom_* have been stable for two edges.
    assign wr_data = wr_en ? rom_ksl_add : 8'd0;
`endif

    // Scan sequencer with registered status, address and lookup-input outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 5'd0;
            op_addr     <= 5'd0;
            rom_fnum    <= 10'd0;
            rom_block   <= 3'd0;
            rom_ksl     <= 2'd0;
            wr_en       <= 1'b0;
            wr_addr     <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun_err <= 1'b0;
`ifdef KSL_SCHED_SKIP_EN
            skip        <= 1'b0;
`endif
        end else begin
            // A tick arriving mid-scan is dropped but flagged; setting beats clearing.
            if (sample_tick && state != IDLE) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end

            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= 5'd0;

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state   <= ADDR;
                        idx     <= 5'd0;
                        op_addr <= 5'd0;
                        busy    <= 1'b1;
                    end
                end
                ADDR: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // Register-file data for op_addr arrived this cycle.
                    rom_fnum  <= reg_fnum;
                    rom_block <= reg_block;
                    rom_ksl   <= reg_ksl;
`ifdef KSL_SCHED_SKIP_EN
                    skip <= (reg_ksl == 2'd0);
                    if (reg_ksl == 2'd0) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                    end else begin
                        state <= HOLD0;
                    end
`else
                    state <= HOLD0;
`endif
                end
                HOLD0: begin
                    state <= HOLD1;
                end
                HOLD1: begin
                    state   <= WRITE;
                    wr_en   <= 1'b1;
                    wr_addr <= idx;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state   <= IDLE;
                        idx     <= 5'd0;
                        op_addr <= 5'd0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state   <= ADDR;
                        idx     <= idx + 5'd1;
                        op_addr <= idx + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksl_sched.sv
// tb_ksl_sched: scoreboard bench for ksl_sched. Models the register file
// (one-cycle read) and the two-stage KSL lookup, queues the expected table
// writes at every accepted tick and pops them as the DUT writes.
// Define KSL_SCHED_SKIP_EN for both RTL and bench to exercise the skip build.
module tb_ksl_sched;

    localparam int NUM_OPS = 18;
    localparam int KSL_TAB [16] = '{0, 32, 40, 45, 48, 51, 53, 55,
                                    56, 58, 59, 60, 61, 62, 63, 64};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       clr_err = 1'b0;
    logic [4:0] op_addr;
    logic [9:0] reg_fnum;
    logic [2:0] reg_block;
    logic [1:0] reg_ksl;
    logic [9:0] rom_fnum;
    logic [2:0] rom_block;
    logic [1:0] rom_ksl;
    logic [7:0] rom_ksl_add;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       overrun_err;

    ksl_sched #(.NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .clr_err(clr_err),
        .op_addr(op_addr), .reg_fnum(reg_fnum), .reg_block(reg_block), .reg_ksl(reg_ksl),
        .rom_fnum(rom_fnum), .rom_block(rom_block), .rom_ksl(rom_ksl),
        .rom_ksl_add(rom_ksl_add), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_wr = 0;
    logic [9:0] mem_fnum [32];
    logic [2:0] mem_block [32];
    logic [1:0] mem_ksl [32];
    logic [7:0] rom_s1;

    // Reference KSL attenuation: table by fnum[9:6], minus 32 per octave below 8, clamped.
    function automatic logic [7:0] ksl_ref(input logic [9:0] f, input logic [2:0] b,
                                           input logic [1:0] k);
        int base;
        base = KSL_TAB[f[9:6]] * 4 - (8 - int'(b)) * 32;
        if (base < 0) base = 0;
        case (k)
            2'd0: return 8'd0;
            2'd1: return 8'(base >> 1);
            2'd2: return 8'(base >> 2);
            default: return 8'(base);
        endcase
    endfunction

    // Expected cycles from tick edge to done cycle for the current register file.
    function automatic int scan_latency();
        int lat;
        lat = 1;
        for (int i = 0; i < NUM_OPS; i++) begin
`ifdef KSL_SCHED_SKIP_EN
            lat += (mem_ksl[i] == 2'd0) ? 3 : 5;
`else
            lat += 5;
`endif
        end
        return lat;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_scan(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = 5'(i);
            e.data = ksl_ref(mem_fnum[i], mem_block[i], mem_ksl[i]);
            exp_q.push_back(e);
        end
    endtask

    // Pulses sample_tick across one edge; returns 1 cycle into the scan.
    task automatic tick_pulse();
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    // Waits (bounded) for done, starting at scan cycle 'start', and checks its cycle.
    task automatic wait_done(input string tag, input int start, input int exp_lat);
        int lat;
        lat = start;
        while (!done && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    // Register file with one-cycle read latency.
    always @(posedge clk) begin
        reg_fnum  <= mem_fnum[op_addr];
        reg_block <= mem_block[op_addr];
        reg_ksl   <= mem_ksl[op_addr];
    end

    // Two-stage lookup: result valid two edges after its inputs settle.
    always @(posedge clk) begin
        rom_s1      <= ksl_ref(rom_fnum, rom_block, rom_ksl);
        rom_ksl_add <= rom_s1;
    end

    // Scoreboard: every table write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            n_wr++;
            $display("write addr %0d data %0d", wr_addr, wr_data);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(exp_e.addr));
                check("wr_data", 32'(wr_data), 32'(exp_e.data));
                check("rom_ksl_held", 32'(rom_ksl), 32'(mem_ksl[wr_addr]));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_fnum[i]  = 10'($urandom);
            mem_block[i] = 3'($urandom);
            mem_ksl[i]   = 2'($urandom_range(1, 3));
        end
        mem_fnum[3] = 10'h200; mem_block[3] = 3'd4; mem_ksl[3] = 2'd1;
        mem_fnum[4] = 10'h200; mem_block[4] = 3'd4; mem_ksl[4] = 2'd2;
        mem_fnum[5] = 10'h200; mem_block[5] = 3'd4; mem_ksl[5] = 2'd3;
        mem_fnum[6] = 10'h200; mem_block[6] = 3'd2; mem_ksl[6] = 2'd2;
        mem_fnum[7] = 10'h03F; mem_block[7] = 3'd7; mem_ksl[7] = 2'd3;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_addr", 32'(op_addr), 32'd0);
        check("rst_rom", {rom_fnum, rom_block, rom_ksl}, 32'd0);
        check("rst_wr", {wr_en, wr_addr, wr_data}, 32'd0);
        check("rst_status", {busy, done, overrun_err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Plain scan: spec operator values, latency, write count, done width.
        n_wr = 0;
        push_scan(NUM_OPS);
        tick_pulse();
        check("busy_scan", 32'(busy), 32'd1);
        check("ref_op3", 32'(exp_q[3].data), 32'd48);
        wait_done("done_latency", 1, scan_latency());
        check("write_count", n_wr, NUM_OPS);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("done_width", 32'(done), 32'd0);

        // Overrun 40 cycles in: flagged, scan unchanged, no restart.
        n_wr = 0;
        push_scan(NUM_OPS);
        tick_pulse();
        repeat (39) @(posedge clk);
        @(negedge clk) sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        check("overrun_set", 32'(overrun_err), 32'd1);
        wait_done("overrun_latency", 41, scan_latency());
        check("overrun_writes", n_wr, NUM_OPS);
        repeat (10) @(posedge clk);
        #1 check("no_restart", 32'(busy), 32'd0);
        check("overrun_sticky", 32'(overrun_err), 32'd1);
        @(negedge clk) clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("overrun_clr", 32'(overrun_err), 32'd0);

        // Tick (with clr_err) during the final WRITE: ignored, flagged, set wins.
        push_scan(NUM_OPS);
        tick_pulse();
        for (int c = 0; c < 200 && !(wr_en && wr_addr == 5'(NUM_OPS - 1)); c++) begin
            @(posedge clk);
            #1;
        end
        check("final_write_seen", 32'(wr_en), 32'd1);
        sample_tick = 1'b1;
        clr_err = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        clr_err = 1'b0;
        check("final_overrun", 32'(overrun_err), 32'd1);
        check("final_done", 32'(done), 32'd1);
        repeat (3) @(posedge clk);
        #1 check("final_no_restart", 32'(busy), 32'd0);
        @(negedge clk) clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;

        // Tick in the done cycle starts a new scan straight away.
        push_scan(NUM_OPS);
        tick_pulse();
        wait_done("pre_done_latency", 1, scan_latency());
        push_scan(NUM_OPS);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_addr", 32'(op_addr), 32'd0);
        check("restart_no_err", 32'(overrun_err), 32'd0);
        wait_done("restart_latency", 1, scan_latency());

        // Reset in HOLD0 of op 7: immediate clear, no write to 7, stays idle.
        n_wr = 0;
        push_scan(7);
        tick_pulse();
        repeat (37) @(posedge clk);
        #1 check("hold0_addr", 32'(op_addr), 32'd7);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {op_addr, rom_fnum, rom_block, rom_ksl}, 32'd0);
        check("abort_wr", {wr_en, wr_addr, wr_data}, 32'd0);
        check("abort_status", {busy, done, overrun_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("abort_idle", 32'(busy), 32'd0);
        check("abort_writes", n_wr, 7);
        check("abort_queue", exp_q.size(), 0);

        // All ksl = 0: writes of 0, scan length depends on the skip build.
        for (int i = 0; i < 32; i++) mem_ksl[i] = 2'd0;
        n_wr = 0;
        push_scan(NUM_OPS);
        tick_pulse();
        wait_done("zero_ksl_latency", 1, scan_latency());
        check("zero_ksl_writes", n_wr, NUM_OPS);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ksl_sched.md
KSL_SCHED -- requirements
Module: ksl_sched

Interface
REQ-001 SHALL have parameter NUM_OPS, default 18: number of operator slots scanned per sample, legal range 1..32.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sample_tick, input, 1: one-cycle pulse that starts a scan of all operators.
REQ-005 SHALL have port clr_err, input, 1: clears overrun_err.
REQ-006 SHALL have port op_addr, output, 5: register-file read address; data returns one cycle later.
REQ-007 SHALL have ports reg_fnum (10), reg_block (3), reg_ksl (2), inputs: register-file read data for op_addr.
REQ-008 SHALL have ports rom_fnum (10), rom_block (3), rom_ksl (2), outputs: registered inputs to the shared KSL attenuation lookup.
REQ-009 SHALL have port rom_ksl_add, input, 8: lookup result, valid two edges after stable inputs.
REQ-010 SHALL have ports wr_en (1), wr_addr (5), wr_data (8), outputs: write port of the per-operator attenuation table.
REQ-011 SHALL have ports busy (1), done (1), overrun_err (1), outputs: scan status.

Function
REQ-012 SHALL implement states IDLE, ADDR, LOAD, HOLD0, HOLD1, WRITE, with operator index i.
REQ-013 IDLE: sample_tick=1 -> ADDR with i=0; otherwise stay.
REQ-014 ADDR: op_addr=i; -> LOAD.
REQ-015 LOAD: capture reg_fnum/reg_block/reg_ksl into rom_fnum/rom_block/rom_ksl at the closing edge; -> HOLD0.
REQ-016 HOLD0, HOLD1: rom_* held unchanged; -> HOLD1 -> WRITE.
REQ-017 WRITE: wr_en=1, wr_addr=i, wr_data=rom_ksl_add; if i==NUM_OPS-1 -> IDLE, else i+=1 and -> ADDR.
REQ-018 rom_* SHALL stay constant from the end of LOAD until WRITE of the same operator, so both lookup stages see the same block and ksl.
REQ-019 Per-operator latency SHALL be 5 cycles; a full scan SHALL be 5*NUM_OPS cycles (90 at default), ADDR of op 0 to WRITE of op NUM_OPS-1.
REQ-020 wr_en SHALL be high only in WRITE, exactly once per operator, in ascending address order.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 done SHALL pulse for one cycle, the first IDLE cycle after the last WRITE.
REQ-023 A sample_tick seen while busy=1, including the final WRITE cycle, SHALL be ignored and SHALL set overrun_err; the scan continues.
REQ-024 A sample_tick in the same cycle as done SHALL be accepted and start a new scan.
REQ-025 overrun_err SHALL be sticky until clr_err=1. If clr_err and a new overrun occur in the same cycle, set wins.
REQ-026 op_addr SHALL hold i in all non-IDLE states and 0 in IDLE.

Reset
REQ-027 rst_n=0 SHALL force IDLE, i=0, and zero op_addr, rom_*, wr_*, busy, done and overrun_err, regardless of clk.
REQ-028 Reset assertion mid-scan SHALL abort the scan with no further writes; the next scan SHALL start only on a new sample_tick.

Configuration
REQ-029 Macro KSL_SCHED_SKIP_EN defined: an operator whose reg_ksl==0 at LOAD goes LOAD -> WRITE with wr_data=0 (3 cycles). rom_* are still updated.
REQ-030 KSL_SCHED_SKIP_EN undefined: every operator takes 5 cycles regardless of ksl.

Verification
REQ-031 Scenario: NUM_OPS=18, op 3 = fnum 0x200, block 4, ksl 1; one tick. Required: wr_addr=3 with wr_data=48; done 91 cycles after the tick; 18 writes total.
REQ-032 Scenario: ksl=2 and ksl=3 at fnum 0x200, block 4. Required: wr_data=24 and 96. At block 2, ksl 2: wr_data=8. At fnum 0x03F: wr_data=0.
REQ-033 Scenario: second tick 40 cycles into a scan. Required: overrun_err=1, scan completes unchanged, no restart. Then clr_err: overrun_err=0.
REQ-034 Scenario: tick in the done cycle. Required: new scan begins, ADDR op 0 on the next cycle, overrun_err stays 0.
REQ-035 Scenario: rst_n low during HOLD0 of op 7. Required: all outputs 0 immediately, no write to address 7, idle until the next tick.
REQ-036 Scenario: KSL_SCHED_SKIP_EN defined, all ksl=0. Required: 18 writes of 0, scan length 54 cycles.
